// File: rtl/b_cache_pkg.sv
// b_cache_pkg: op codes, per-op length/window/delay table and FSM states
// shared by the B-cache write sequencer and the din mapping stage.
package b_cache_pkg;

    typedef enum logic [3:0] {
        OP_IDLE      = 4'b0000,
        OP_TRANSPOSE = 4'b1001,
        OP_INV       = 4'b1010,
        OP_NL_PRD    = 4'b1101,
        OP_NL_NEW    = 4'b1110,
        OP_NL_UPD    = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [3:0] LEN_PRD = 4'd3;
    localparam logic [3:0] LEN_NEW = 4'd6;
    localparam logic [3:0] LEN_UPD = 4'd5;
    localparam logic [3:0] LEN_INV = 4'd9;
    localparam logic [3:0] WF_STD  = 4'd1;
    localparam logic [3:0] WF_INV  = 4'd7;
    localparam logic [1:0] D_STD   = 2'd1;
    localparam logic [1:0] D_TRANSPOSE = 2'd2;

    function automatic logic op_legal(input logic [3:0] op);
        return op inside {OP_TRANSPOSE, OP_INV, OP_NL_PRD, OP_NL_NEW, OP_NL_UPD};
    endfunction

    // fixed lengths only; TRANSPOSE takes its length from the command
    function automatic logic [3:0] op_len(input logic [3:0] op);
        return op == OP_NL_PRD ? LEN_PRD :
               op == OP_NL_NEW ? LEN_NEW :
               op == OP_NL_UPD ? LEN_UPD :
               op == OP_INV    ? LEN_INV : 4'd0;
    endfunction

    function automatic logic [3:0] op_wf(input logic [3:0] op);
        return op == OP_INV ? WF_INV : WF_STD;
    endfunction

    function automatic logic [1:0] op_dly(input logic [3:0] op);
        return op == OP_TRANSPOSE ? D_TRANSPOSE : D_STD;
    endfunction

endpackage

// File: rtl/b_cache_wr_align.sv
// b_cache_wr_align: delays write valid/address by 1 or 2 cycles so the B-cache
// write enable lines up with the mapped din; address holds between writes.
module b_cache_wr_align #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dly2_i,
    input  logic          v_i,
    input  logic [AW-1:0] a_i,
    output logic          wea_o,
    output logic [AW-1:0] addr_o
);

    logic          s_v_q;
    logic [AW-1:0] s_a_q;
    logic          wea_q;
    logic [AW-1:0] addr_q;
    logic          v_d;
    logic [AW-1:0] a_d;

    always_comb begin
        v_d = dly2_i ? s_v_q : v_i;
        a_d = dly2_i ? s_a_q : a_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_v_q  <= 1'b0;
            s_a_q  <= '0;
            wea_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            s_v_q <= v_i;
            s_a_q <= a_i;
            wea_q <= v_d;
            if (v_d) addr_q <= a_d;
        end
    end

    assign wea_o  = wea_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/b_cache_wr_ctrl.sv
// b_cache_wr_ctrl: one-command-at-a-time sequencer for the B-cache write path,
// driving op select, sequence count, transpose-buffer reads and aligned writes.
module b_cache_wr_ctrl
    import b_cache_pkg::*;
#(
    parameter int SEQ_CNT_DW = 10,
    parameter int BCA_AW     = 10,
    parameter int TB_AW      = 10
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [SEQ_CNT_DW-1:0] cmd_len,
    input  logic [BCA_AW-1:0]     cmd_base,
    input  logic [TB_AW-1:0]      cmd_tb_base,
    output logic [3:0]            B_cache_in_sel,
    output logic [SEQ_CNT_DW-1:0] seq_cnt_out,
    output logic                  B_cache_TB_enb,
    output logic [TB_AW-1:0]      B_cache_TB_addrb,
    output logic                  B_cache_wea,
    output logic [BCA_AW-1:0]     B_cache_addra,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_err
);

    state_e                state_q, state_d;
    logic [3:0]            op_q, op_d, sel_q, sel_d;
    logic [SEQ_CNT_DW-1:0] len_q, len_d, seq_q, seq_d, wf;
    logic [BCA_AW-1:0]     base_q, base_d, wr_a;
    logic [TB_AW-1:0]      tbb_q, tbb_d, tba_q, tba_d;
    logic                  tbe_q, tbe_d, cnt_q, cnt_d;
    logic                  done_q, done_d, err_q, err_d, rdy_q, busy_q;
    logic                  acc_ok, wr_v;
    logic [SEQ_CNT_DW-1:0] acc_len;

    always_comb begin
        acc_len = cmd_op == OP_TRANSPOSE ? cmd_len : SEQ_CNT_DW'(op_len(cmd_op));
        acc_ok  = op_legal(cmd_op) && acc_len != '0;
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        base_d  = base_q;
        tbb_d   = tbb_q;
        tba_d   = tba_q;
        cnt_d   = cnt_q;
        seq_d   = '0;
        sel_d   = '0;
        tbe_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                op_d   = cmd_op;
                len_d  = acc_len;
                base_d = cmd_base;
                tbb_d  = cmd_tb_base;
                if (acc_ok) begin
                    state_d = ST_RUN;
                    seq_d   = SEQ_CNT_DW'(1);
                    sel_d   = cmd_op;
                    tbe_d   = cmd_op == OP_TRANSPOSE;
                    if (cmd_op == OP_TRANSPOSE) tba_d = cmd_tb_base;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = !op_legal(cmd_op);
                end
            end
            ST_RUN: begin
                sel_d = op_q;
                if (seq_q == len_q) begin
                    state_d = ST_DRAIN;
                    cnt_d   = op_dly(op_q) == D_TRANSPOSE;
                end else begin
                    seq_d = seq_q + SEQ_CNT_DW'(1);
                    tbe_d = op_q == OP_TRANSPOSE;
                    if (op_q == OP_TRANSPOSE) tba_d = tbb_q + TB_AW'(seq_q);
                end
            end
            ST_DRAIN: begin
                if (cnt_q) begin
                    cnt_d = 1'b0;
                    sel_d = op_q;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // write request for the seq value currently on seq_cnt_out
    always_comb begin
        wf   = SEQ_CNT_DW'(op_wf(op_q));
        wr_v = state_q == ST_RUN && seq_q >= wf;
        wr_a = base_q + BCA_AW'(seq_q - wf);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            len_q   <= '0;
            base_q  <= '0;
            tbb_q   <= '0;
            tba_q   <= '0;
            cnt_q   <= 1'b0;
            seq_q   <= '0;
            sel_q   <= '0;
            tbe_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            base_q  <= base_d;
            tbb_q   <= tbb_d;
            tba_q   <= tba_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            sel_q   <= sel_d;
            tbe_q   <= tbe_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= state_d == ST_IDLE;
            busy_q  <= state_d != ST_IDLE;
        end
    end

    b_cache_wr_align #(.AW(BCA_AW)) u_align (
        .clk    (clk),
        .rst_n  (sys_rst_n),
        .dly2_i (op_dly(op_q) == D_TRANSPOSE),
        .v_i    (wr_v),
        .a_i    (wr_a),
        .wea_o  (B_cache_wea),
        .addr_o (B_cache_addra)
    );

    assign cmd_ready        = rdy_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign cmd_err          = err_q;
    assign seq_cnt_out      = seq_q;
    assign B_cache_in_sel   = sel_q;
    assign B_cache_TB_enb   = tbe_q;
    assign B_cache_TB_addrb = tba_q;

endmodule

// File: tb/tb_b_cache_wr_ctrl.sv
// tb_b_cache_wr_ctrl: directed and random commands checked cycle by cycle
// against a timeline model of each command.
module tb_b_cache_wr_ctrl;

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_op = '0;
    logic [9:0] cmd_len = '0, cmd_base = '0, cmd_tb_base = '0;
    logic       cmd_ready, B_cache_TB_enb, B_cache_wea, busy, done, cmd_err;
    logic [3:0] B_cache_in_sel;
    logic [9:0] seq_cnt_out, B_cache_TB_addrb, B_cache_addra;

    int         checks = 0, failures = 0;
    logic [9:0] last_addr = '0, last_tba = '0;

    always #5 clk = ~clk;

    b_cache_wr_ctrl dut (
        .clk              (clk),
        .sys_rst_n        (sys_rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_len          (cmd_len),
        .cmd_base         (cmd_base),
        .cmd_tb_base      (cmd_tb_base),
        .B_cache_in_sel   (B_cache_in_sel),
        .seq_cnt_out      (seq_cnt_out),
        .B_cache_TB_enb   (B_cache_TB_enb),
        .B_cache_TB_addrb (B_cache_TB_addrb),
        .B_cache_wea      (B_cache_wea),
        .B_cache_addra    (B_cache_addra),
        .busy             (busy),
        .done             (done),
        .cmd_err          (cmd_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle();
        chk("idle_ready", 32'(cmd_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_err", 32'(cmd_err), 0);
        chk("idle_seq", 32'(seq_cnt_out), 0);
        chk("idle_sel", 32'(B_cache_in_sel), 0);
        chk("idle_tbe", 32'(B_cache_TB_enb), 0);
        chk("idle_wea", 32'(B_cache_wea), 0);
        chk("idle_tba", 32'(B_cache_TB_addrb), 32'(last_tba));
        chk("idle_addra", 32'(B_cache_addra), 32'(last_addr));
    endtask

    // entered during an IDLE cycle; returns during the IDLE cycle after the command
    task automatic run_cmd(input logic [3:0] op, input logic [9:0] len, input logic [9:0] base,
                           input logic [9:0] tbb, input int abort_at);
        bit legal, bad, tr, wr;
        int L, wf, d, total, k, nw, ew;
        legal = op inside {4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b1111};
        tr    = op == 4'b1001;
        L     = tr ? int'(len) : op == 4'b1101 ? 3 : op == 4'b1110 ? 6 :
                op == 4'b1111 ? 5 : op == 4'b1010 ? 9 : 0;
        wf    = op == 4'b1010 ? 7 : 1;
        d     = tr ? 2 : 1;
        bad   = !legal || L == 0;
        total = bad ? 1 : L + d + 1;
        ew    = bad ? 0 : L - wf + 1;
        nw    = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_base = base; cmd_tb_base = tbb;
        step();
        for (int t = 1; t <= total; t++) begin
            k  = t - d;
            wr = !bad && k >= wf && k <= L;
            if (!bad && tr && t <= L) last_tba = tbb + 10'(t - 1);
            if (wr) last_addr = base + 10'(k - wf);
            chk("ready", 32'(cmd_ready), 0);
            chk("busy", 32'(busy), 1);
            chk("seq", 32'(seq_cnt_out), (!bad && t <= L) ? t : 0);
            chk("sel", 32'(B_cache_in_sel), (!bad && t <= L + d) ? 32'(op) : 0);
            chk("tbe", 32'(B_cache_TB_enb), 32'(!bad && tr && t <= L));
            chk("tba", 32'(B_cache_TB_addrb), 32'(last_tba));
            chk("wea", 32'(B_cache_wea), 32'(wr));
            chk("addra", 32'(B_cache_addra), 32'(last_addr));
            chk("done", 32'(done), 32'(t == total));
            chk("err", 32'(cmd_err), 32'(t == total && !legal));
            nw += int'(B_cache_wea);
            if (t == abort_at) begin
                sys_rst_n = 1'b0;
                cmd_valid = 1'b0;
                #1;
                last_addr = '0;
                last_tba  = '0;
                chk_idle();
                #2 sys_rst_n = 1'b1;
                step();
                chk_idle();
                return;
            end
            cmd_valid = 1'b1;
            cmd_op = 4'($urandom); cmd_len = 10'($urandom);
            cmd_base = 10'($urandom); cmd_tb_base = 10'($urandom);
            step();
        end
        chk("nwrites", 32'(nw), 32'(ew));
        chk_idle();
    endtask

    initial begin
        logic [3:0] op;
        int r;
        #12;
        chk_idle();
        sys_rst_n = 1'b1;
        step();
        chk_idle();
        run_cmd(4'b1101, 10'd0, 10'h020, 10'h000, 0);
        run_cmd(4'b1010, 10'd0, 10'h040, 10'h000, 0);
        run_cmd(4'b1001, 10'd4, 10'h3FF, 10'h3FE, 0);
        run_cmd(4'b0101, 10'd0, 10'h123, 10'h000, 0);
        run_cmd(4'b1001, 10'd0, 10'h055, 10'h066, 0);
        run_cmd(4'b1110, 10'd0, 10'h100, 10'h000, 3);
        run_cmd(4'b1111, 10'd0, 10'h200, 10'h000, 0);
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 7);
            op = r < 2 ? 4'b1001 : r == 2 ? 4'b1010 : r == 3 ? 4'b1101 :
                 r == 4 ? 4'b1110 : r == 5 ? 4'b1111 : 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    step();
                    chk_idle();
                end
            end
            run_cmd(op, 10'($urandom_range(0, 12)), 10'($urandom), 10'($urandom),
                    ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/b_cache_wr_ctrl.md
Name: b_cache_wr_ctrl

Overview:
Sequencer for the B-cache write path. Accepts one write command at a time (predict, new-landmark, update, transpose, 2x2 inverse). Drives the operation select and sequence counter into the B-cache din mapping stage, the read port of the transpose buffer, and a latency-aligned write enable and address for the B cache. Sits between the top-level EKF stage FSM and the din mapping/B-cache pair.

Parameters:
SEQ_CNT_DW, 10, width of seq_cnt_out and cmd_len
BCA_AW, 10, B-cache write address width
TB_AW, 10, transpose-buffer read address width

Ports:
clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  4  operation code; same encoding as B_cache_in_sel
cmd_len  in  SEQ_CNT_DW  row count; used by TRANSPOSE only
cmd_base  in  BCA_AW  first B-cache write address
cmd_tb_base  in  TB_AW  first transpose-buffer read address
B_cache_in_sel  out  4  operation select to the din mapping stage
seq_cnt_out  out  SEQ_CNT_DW  sequence counter to the din mapping stage
B_cache_TB_enb  out  1  transpose-buffer read enable
B_cache_TB_addrb  out  TB_AW  transpose-buffer read address
B_cache_wea  out  1  B-cache write enable, aligned to B_cache_din
B_cache_addra  out  BCA_AW  B-cache write address
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at command end
cmd_err  out  1  one-cycle pulse with done for an illegal op

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0 except cmd_ready=1; state IDLE; write pipeline cleared. Reset mid-command abandons the command with no done pulse.
- Op codes: IDLE=0000, TRANSPOSE=1001, INV=1010, NL_PRD=1101, NL_NEW=1110, NL_UPD=1111. Any other code is illegal.
- Per-op LEN, write window [WF..LEN] and delay D:
  - PRD: LEN 3, window 1..3, D=1
  - NEW: LEN 6, window 1..6, D=1
  - UPD: LEN 5, window 1..5, D=1
  - INV: LEN 9, window 7..9, D=1
  - TRANSPOSE: LEN=cmd_len, window 1..LEN, D=2 (1-cycle TB read latency plus the mapping register)
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: a handshake (cmd_valid & cmd_ready) latches op, len, base and tb_base.
  - Legal op with LEN>0: go to RUN.
  - Illegal op, or TRANSPOSE with cmd_len=0: go to DONE with cmd_err=1 for the illegal case, 0 for the zero-length case; no writes.
- RUN: first cycle has seq_cnt_out=1; it increments by 1 per cycle. B_cache_in_sel=op.
  - TRANSPOSE only: B_cache_TB_enb=1 and B_cache_TB_addrb=tb_base+seq-1.
  - When seq_cnt_out=LEN, go to DRAIN.
- DRAIN: lasts D cycles. seq_cnt_out=0, B_cache_in_sel held at op, TB_enb=0. Then go to DONE.
- DONE: one cycle. done=1, B_cache_in_sel=0, seq_cnt_out=0. Then go to IDLE.
- Write alignment: seq value k in the window yields B_cache_wea=1 exactly D cycles after the RUN cycle carrying k, with B_cache_addra=base+(k-WF). Otherwise wea=0; addra holds its last value.
- Implementation: a D-deep (max 2) valid/address shift pipeline. The last write lands in the final DRAIN cycle.
- Address arithmetic wraps modulo 2^BCA_AW and 2^TB_AW; no saturation.
- cmd_valid outside IDLE is ignored; no queuing.
- All outputs are registered.

Decomposition:
- Shared package (b_cache_pkg): op codes, the LEN/WF/D table as localparams, and FSM state encodings. The din mapping stage imports the same op codes.
- One natural sub-module, b_cache_wr_align: the D-selectable valid/address delay pipeline. Everything else stays in b_cache_wr_ctrl.

Test Plan:
- Reset then NL_PRD, base=0x20 -> seq 1,2,3 on consecutive cycles; wea high 3 cycles, each one cycle after its seq, addra 0x20,0x21,0x22; done one cycle after the last write; cmd_ready low throughout.
- INV, base=0x40 -> seq 1..9; wea only for k=7,8,9 with addra 0x40,0x41,0x42; exactly 3 writes; done pulse; in_sel=1010 through DRAIN.
- TRANSPOSE, len=4, tb_base=0x3FE, base=0x3FF -> TB_addrb 0x3FE,0x3FF,0x000,0x001; wea two cycles after each seq; addra 0x3FF,0x000,0x001,0x002; in_sel held 2 DRAIN cycles.
- Illegal op 0101, and separately TRANSPOSE with len=0 -> no RUN cycles, wea never high, done pulse; cmd_err=1 only for 0101.
- sys_rst_n low during seq=3 of NL_NEW -> all outputs 0 immediately, no done; next NL_UPD command runs cleanly with 5 writes.
- cmd_valid held high continuously across back-to-back commands -> next accept only on the cycle after done; no overlap of wea between commands.
